axi_mem_slave: RTL
==================

// Module: axi_mem_slave
// PURPOSE
//  Single-beat AXI-style memory responder: the target end of the AR/R and AW/W/B channels driven by
//  the core's load/store initiators. Holds a synthesizable dword-wide RAM with configurable read
//  latency, byte-lane writes from the WUSER size code, and decode-error responses outside its window.
//  It replaces the host-side memory model in simulation and is the on-chip RAM in synthesis.
// PARAMETERS
//  MEM_BASE    32'h8000_0000  byte base address of the window
//  DEPTH_LOG2  12             log2 of RAM depth in 64-bit dwords (window = 8<<DEPTH_LOG2 bytes)
//  RD_LATENCY  1              cycles from AR handshake to RVALID; legal 1..15
// PORTS
//  ACLK     in   1   clock, all state on rising edge
//  ARESETn  in   1   asynchronous, active-low reset
//  ARVALID  in   1   read address valid
//  ARREADY  out  1   read address accepted
//  ARADDR   in   32  read byte address
//  ARPROT   in   3   ignored
//  RVALID   out  1   read data valid
//  RREADY   in   1   initiator accepts read data
//  RLAST    out  1   last beat; always equal to RVALID
//  RDATA    out  64  read dword
//  RRESP    out  2   00 OKAY, 11 DECERR
//  AWVALID  in   1   write address valid
//  AWREADY  out  1   write address accepted
//  AWADDR   in   32  write byte address
//  AWPROT   in   3   ignored
//  WVALID   in   1   write data valid
//  WREADY   out  1   write data accepted
//  WDATA    in   64  write data, LSB-aligned (byte 0 of the access in WDATA[7:0])
//  WLAST    in   1   must be 1 on every beat
//  WUSER    in   4   size code: 0001 byte, 0010 half, 0100 word, 1000 dword; other values = dword
//  BVALID   out  1   write response valid
//  BREADY   in   1   initiator accepts response
//  BRESP    out  2   00 OKAY, 10 SLVERR, 11 DECERR
// BEHAVIOUR
//  Reset (async assert, sync release): ARREADY=1, AWREADY=1, WREADY=1, RVALID=0, RLAST=0,
//   RDATA=0, RRESP=00, BVALID=0, BRESP=00; both FSMs to IDLE. RAM contents not cleared.
//   Reset mid-transaction discards it: no R/B beat is produced afterwards.
//  Read FSM R_IDLE -> R_WAIT -> R_DATA -> R_IDLE:
//   - R_IDLE: ARREADY=1. ARVALID&&ARREADY latches ARADDR, loads counter=RD_LATENCY-1, ARREADY->0.
//   - R_WAIT: counter decrements each cycle; at 0 RAM row captured into RDATA, go R_DATA.
//     RD_LATENCY=1 skips R_WAIT: RVALID rises the cycle after the AR handshake.
//   - R_DATA: RVALID=RLAST=1; RDATA/RRESP held stable until RREADY. On RVALID&&RREADY -> R_IDLE,
//     ARREADY=1 the next cycle (no back-to-back overlap; one read outstanding).
//   - Row index = (ARADDR-MEM_BASE)>>3; addr[2:0] ignored, full dword returned.
//   - ARADDR outside [MEM_BASE, MEM_BASE+window): RDATA=0, RRESP=11, same timing.
//  Write FSM W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP:
//   - AW and W accepted independently in any order or same cycle; AWREADY drops after AW taken,
//     WREADY drops after W taken, both return to 1 on B handshake.
//   - Commit in the cycle both are held (or arrive): byte lanes = size mask << addr[2:0],
//     data = WDATA << (8*addr[2:0]); lanes beyond byte 7 are dropped (no wrap to next row).
//   - BVALID rises the cycle after commit, held with BRESP until BREADY; one write outstanding.
//   - WLAST=0: no RAM update, BRESP=10. Out-of-window address: no update, BRESP=11.
//  Read/write interaction: independent channels. If a write commits in the same cycle a read
//   captures the same row, the read returns the pre-write value; a read captured later sees it.
//  RDATA, RRESP, BRESP are registers; no combinational path from any input to any output.
// TESTING
//  1 Reset: ARESETn=0 -> ARREADY=AWREADY=WREADY=1, RVALID=BVALID=0; release keeps them.
//  2 AW+W same cycle addr 8000_0010, WDATA=64'h1122334455667788, WUSER=1000 -> BVALID next cycle,
//    BRESP=00; read 8000_0010 with RD_LATENCY=1 -> RVALID 1 cycle after AR, RDATA=1122334455667788.
//  3 Byte write addr 8000_0013, WDATA=8'hAB, WUSER=0001 onto prior row -> read returns
//    1122_3344_AB66_7788; word write at 8000_0016 updates only bytes 6,7 (lanes 8,9 dropped).
//  4 W 3 cycles before AW; BREADY low 4 cycles -> BVALID/BRESP stable, AWREADY/WREADY stay 0
//    until B handshake; RREADY low 5 cycles -> RDATA stable, ARREADY=0 until R handshake.
//  5 Read 0000_1000 -> RRESP=11, RDATA=0; write 9000_0000 -> BRESP=11, RAM unchanged;
//    WLAST=0 -> BRESP=10, RAM unchanged.
//  6 RD_LATENCY=4: RVALID exactly 4 cycles after AR; ARESETn pulsed in R_WAIT -> no RVALID ever.

Source files
------------

// File: rtl/axi_mem_slave_if.sv
// Single-beat AXI-style bus between the core's load/store initiators and the memory responder.
interface axi_mem_slave_if;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        RVALID;
    logic        RREADY;
    logic        RLAST;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        WVALID;
    logic        WREADY;
    logic [63:0] WDATA;
    logic        WLAST;
    logic [3:0]  WUSER;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;

    modport slave (
        input  ARVALID, ARADDR, ARPROT, RREADY,
        input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WLAST, WUSER, BREADY,
        output ARREADY, RVALID, RLAST, RDATA, RRESP,
        output AWREADY, WREADY, BVALID, BRESP
    );

    modport master (
        output ARVALID, ARADDR, ARPROT, RREADY,
        output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WLAST, WUSER, BREADY,
        input  ARREADY, RVALID, RLAST, RDATA, RRESP,
        input  AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/axi_mem_slave.sv
// Single-beat AXI-style memory responder: dword RAM with configurable read latency,
// byte-lane writes sized by WUSER, and DECERR outside the address window.
module axi_mem_slave #(
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    axi_mem_slave_if.slave   bus
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned ROW_W  = DEPTH_LOG2;
    localparam logic [32:0] WINDOW = 33'(8) << DEPTH_LOG2;
    localparam logic [3:0]  LAT_M1 = 4'(RD_LATENCY - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;

    logic [63:0] mem [DEPTH];

    // Address decode for both channels
    logic [31:0]      ar_off, aw_off;
    logic             ar_win, aw_win;
    logic [ROW_W-1:0] ar_row, aw_row;

    assign ar_off = bus.ARADDR - MEM_BASE;
    assign aw_off = bus.AWADDR - MEM_BASE;
    assign ar_win = ({1'b0, ar_off} < WINDOW);
    assign aw_win = ({1'b0, aw_off} < WINDOW);
    assign ar_row = ar_off[ROW_W+2:3];
    assign aw_row = aw_off[ROW_W+2:3];

    // ---------------- read channel ----------------
    r_state_t         r_state, r_next;
    logic [3:0]       r_cnt, r_cnt_next;
    logic [ROW_W-1:0] rd_row, rd_row_next, cap_row;
    logic             rd_win, rd_win_next, cap_win;
    logic             r_capture;
    logic             arready_q, rvalid_q;
    logic [63:0]      rdata_q;
    logic [1:0]       rresp_q;

    always_comb begin
        r_next      = r_state;
        r_cnt_next  = r_cnt;
        rd_row_next = rd_row;
        rd_win_next = rd_win;
        r_capture   = 1'b0;
        cap_row     = rd_row;
        cap_win     = rd_win;
        case (r_state)
            R_IDLE: begin
                if (bus.ARVALID && arready_q) begin
                    rd_row_next = ar_row;
                    rd_win_next = ar_win;
                    if (RD_LATENCY <= 1) begin
                        r_capture = 1'b1;
                        cap_row   = ar_row;
                        cap_win   = ar_win;
                        r_next    = R_DATA;
                    end else begin
                        r_cnt_next = LAT_M1;
                        r_next     = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                r_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    r_capture = 1'b1;
                    r_next    = R_DATA;
                end
            end
            R_DATA: begin
                if (bus.RREADY) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= R_IDLE;
            r_cnt     <= 4'd0;
            rd_row    <= '0;
            rd_win    <= 1'b0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= 64'd0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state   <= r_next;
            r_cnt     <= r_cnt_next;
            rd_row    <= rd_row_next;
            rd_win    <= rd_win_next;
            arready_q <= (r_next == R_IDLE);
            rvalid_q  <= (r_next == R_DATA);
            // Reads sample the array before any same-edge write lands
            if (r_capture) begin
                rdata_q <= cap_win ? mem[cap_row] : 64'd0;
                rresp_q <= cap_win ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    assign bus.ARREADY = arready_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RLAST   = rvalid_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;

    // ---------------- write channel ----------------
    w_state_t         w_state, w_next;
    logic [ROW_W-1:0] aw_row_q, c_row;
    logic             aw_win_q, c_win;
    logic [2:0]       aw_lo_q, c_lo;
    logic [63:0]      wdata_q, c_data;
    logic [3:0]       wuser_q, c_user;
    logic             wlast_q, c_last;
    logic             aw_hs, w_hs, latch_aw, latch_w, commit;
    logic             awready_q, wready_q, bvalid_q;
    logic [1:0]       bresp_q, bresp_next;
    logic [7:0]       size_mask, mem_be;
    logic [15:0]      lanes;
    logic [63:0]      mem_wd;
    logic             mem_we;

    assign aw_hs = bus.AWVALID && awready_q;
    assign w_hs  = bus.WVALID && wready_q;

    always_comb begin
        w_next   = w_state;
        latch_aw = 1'b0;
        latch_w  = 1'b0;
        commit   = 1'b0;
        // Held halves come from registers, the arriving half straight from the bus
        c_row  = (w_state == W_HAVE_AW) ? aw_row_q : aw_row;
        c_win  = (w_state == W_HAVE_AW) ? aw_win_q : aw_win;
        c_lo   = (w_state == W_HAVE_AW) ? aw_lo_q  : bus.AWADDR[2:0];
        c_data = (w_state == W_HAVE_W)  ? wdata_q  : bus.WDATA;
        c_user = (w_state == W_HAVE_W)  ? wuser_q  : bus.WUSER;
        c_last = (w_state == W_HAVE_W)  ? wlast_q  : bus.WLAST;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end else if (aw_hs) begin
                    latch_aw = 1'b1;
                    w_next   = W_HAVE_AW;
                end else if (w_hs) begin
                    latch_w = 1'b1;
                    w_next  = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (bus.BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        case (c_user)
            4'b0001: size_mask = 8'h01;
            4'b0010: size_mask = 8'h03;
            4'b0100: size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Lanes shifted past byte 7 fall off rather than wrapping into the next row
    assign lanes  = 16'(size_mask) << c_lo;
    assign mem_be = lanes[7:0];
    assign mem_wd = c_data << {c_lo, 3'b000};
    assign mem_we = commit && c_win && c_last;

    always_comb begin
        if (!c_last)     bresp_next = RESP_SLVERR;
        else if (!c_win) bresp_next = RESP_DECERR;
        else             bresp_next = RESP_OKAY;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state   <= W_IDLE;
            aw_row_q  <= '0;
            aw_win_q  <= 1'b0;
            aw_lo_q   <= 3'd0;
            wdata_q   <= 64'd0;
            wuser_q   <= 4'd0;
            wlast_q   <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state   <= w_next;
            awready_q <= (w_next == W_IDLE) || (w_next == W_HAVE_W);
            wready_q  <= (w_next == W_IDLE) || (w_next == W_HAVE_AW);
            bvalid_q  <= (w_next == W_RESP);
            if (latch_aw) begin
                aw_row_q <= aw_row;
                aw_win_q <= aw_win;
                aw_lo_q  <= bus.AWADDR[2:0];
            end
            if (latch_w) begin
                wdata_q <= bus.WDATA;
                wuser_q <= bus.WUSER;
                wlast_q <= bus.WLAST;
            end
            if (commit) bresp_q <= bresp_next;
        end
    end

    // RAM array carries no reset so it maps onto a plain memory macro
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (mem_be[b]) mem[c_row][8*b +: 8] <= mem_wd[8*b +: 8];
            end
        end
    end

    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BRESP   = bresp_q;

    logic unused_ok;
    assign unused_ok = ^{bus.ARPROT, bus.AWPROT, ar_off, aw_off, lanes[15:8]};

endmodule
